mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits beside the single-cycle integer ALU and handles all eight M-extension ops that the ALU does not compute.
- The decode/control stage issues an operation with a start/ready handshake. The stage stalls until a one-cycle result-valid pulse.
- Datapath is radix-2: shift-add for multiply, restoring for divide. Signed ops use magnitude conversion with a final sign fix-up.

Parameters:
- DWIDTH, 32, operand/result width (XLEN); must be even and >= 8

Ports:
- Clk  input  1  system clock, rising-edge
- Reset  input  1  synchronous, active-high reset
- MD_Start  input  1  request valid; accepted only when MD_Ready=1
- MD_OP  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- MD_In_A  input  DWIDTH  rs1 operand
- MD_In_B  input  DWIDTH  rs2 operand
- MD_Ready  output  1  high in IDLE only
- MD_Busy  output  1  high in CALC or DONE
- MD_Out  output  DWIDTH  result; holds until next acceptance
- MD_Valid  output  1  one-cycle pulse, MD_Out valid

Behaviour:
- Interface (already decided): one clock, Clk; Reset is synchronous, active-high.
- Reset: state=IDLE, MD_Ready=1, MD_Busy=0, MD_Valid=0, MD_Out=0, all internal registers 0. Reset mid-operation aborts immediately with no MD_Valid pulse.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on MD_Start. Operands, op, sign flags and magnitudes are latched, and the counter is loaded with DWIDTH-1.
  - IDLE -> DONE directly for fast paths, with the result latched.
  - CALC: one bit per cycle. -> DONE when counter==0.
  - DONE: MD_Valid=1 for exactly one cycle, MD_Out updated in the same cycle, then -> IDLE.
- Latency (accepting edge = E0):
  - Iterative ops: MD_Valid high in the cycle after edge E0+DWIDTH+1.
  - Fast paths: MD_Valid high in the cycle after E0+1.
  - Back-to-back issue: the earliest next acceptance is the DONE cycle's following cycle.
- MD_Start is ignored while MD_Ready=0; there is no queueing. MD_In_A, MD_In_B and MD_OP may change freely after acceptance.
- Multiply:
  - 2*DWIDTH-bit product of magnitudes; negate if the result sign is set.
  - MUL returns the low half. MULH, MULHSU and MULHU return the high half.
  - MULH treats A and B as signed. MULHSU treats A as signed, B as unsigned. MULHU treats both as unsigned.
- Divide:
  - Restoring, on unsigned magnitudes.
  - Quotient sign = sA^sB for DIV. Remainder takes the sign of the dividend (REM).
- Fast paths (DONE next cycle):
  - B==0: quotient = all ones (DIV/DIVU), remainder = A (REM/REMU).
  - Signed overflow, A=100..0 and B=all ones: DIV returns A, REM returns 0.
- All arithmetic is modulo 2^DWIDTH. There are no exceptions and no flags.

Optional Feature:
- Macro: MUL_DIV_FAST_MUL_EN
- Defined:
  - The four multiply ops compute in a single CALC cycle using a native 2*DWIDTH multiplier (DSP inference).
  - MD_Valid appears in the cycle after E0+2.
  - Divide path unchanged.
- Undefined:
  - Multiply is iterative with DWIDTH+1 latency.
  - No `*` operator appears in the RTL.

Decomposition:
- Package mul_div_pkg:
  - MD_OP funct3 localparams (MD_MUL..MD_REMU).
  - FSM state typedef (IDLE/CALC/DONE).
  - Helper constant for counter width, $clog2(DWIDTH).
- Sub-module md_operand_prep (combinational), instantiated twice:
  - Input stage: magnitude and sign extraction per op signedness.
  - Output stage: conditional two's-complement negate of the 2*DWIDTH result.

Test Plan:
- Multiply results:
  - MUL 7 x 0xFFFFFFFD -> MD_Out=0xFFFFFFEB, MD_Valid in the cycle after E0+33 (E0+2 with MUL_DIV_FAST_MUL_EN).
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- Divide corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
  - All of these give MD_Valid in the cycle after E0+1.
- Busy handling: MD_Start held high with new operands during CALC -> ignored. MD_Ready=0 until after the MD_Valid pulse, then the second op is accepted with correct result.
- Reset mid-op: Reset asserted 10 cycles into DIV -> next cycle state IDLE, MD_Out=0, MD_Ready=1, no MD_Valid pulse. A subsequent MUL 3x4 returns 12.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the RV32M multiply/divide unit.
package mul_div_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef logic [1:0] md_state_t;

  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_CALC = 2'd1;
  localparam md_state_t ST_DONE = 2'd2;

  // Width of the iteration counter, which counts DWIDTH-1 down to 0.
  function automatic int unsigned cnt_width(input int unsigned dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/md_operand_prep.sv
// Two-lane conditional two's-complement negate: operand magnitudes on the way in,
// result sign fix-up on the way out.
module md_operand_prep #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         a_neg_i,
  input  logic         b_neg_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o
);

  assign a_o = a_neg_i ? (~a_i + W'(1)) : a_i;
  assign b_o = b_neg_i ? (~b_i + W'(1)) : b_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MUL_DIV_FAST_MUL_EN to compute the multiply ops in one cycle on a native multiplier.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MD_Start,
  input  logic [2:0]        MD_OP,
  input  logic [DWIDTH-1:0] MD_In_A,
  input  logic [DWIDTH-1:0] MD_In_B,
  output logic              MD_Ready,
  output logic              MD_Busy,
  output logic [DWIDTH-1:0] MD_Out,
  output logic              MD_Valid
);

  localparam int unsigned DW = DWIDTH;
  localparam int unsigned PW = 2 * DWIDTH;
  localparam int unsigned CW = cnt_width(DWIDTH);

  md_state_t         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [DW-1:0]     b_mag_q, b_mag_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [DW-1:0]     out_q, out_d;
  logic              valid_q, valid_d;
  logic              ready_q, busy_q;

  logic              a_signed_c, b_signed_c;
  logic              a_neg_c, b_neg_c, neg_c;
  logic [DW-1:0]     a_mag_c, b_mag_c;
  logic              b_zero_c, ovf_c;
  logic [DW:0]       div_trial_c;
  logic [PW-1:0]     div_val_c, mul_fix_c, div_fix_c;
  logic [DW-1:0]     res_c;
`ifdef MUL_DIV_FAST_MUL_EN
  logic [PW-1:0]     mul_full_c;
`else
  logic [DW:0]       mul_sum_c;
`endif

  // Operand signedness per funct3
  always_comb begin
    a_signed_c = 1'b0;
    b_signed_c = 1'b0;
    case (MD_OP)
      MD_MULH, MD_DIV, MD_REM: begin
        a_signed_c = 1'b1;
        b_signed_c = 1'b1;
      end
      MD_MULHSU: a_signed_c = 1'b1;
      MD_MUL, MD_MULHU, MD_DIVU, MD_REMU: ;
      default: ;
    endcase
  end

  assign a_neg_c  = a_signed_c & MD_In_A[DW-1];
  assign b_neg_c  = b_signed_c & MD_In_B[DW-1];
  // Remainder follows the dividend; product and quotient follow sA^sB.
  assign neg_c    = (MD_OP == MD_REM) ? a_neg_c : (a_neg_c ^ b_neg_c);
  assign b_zero_c = MD_OP[2] & (MD_In_B == '0);
  assign ovf_c    = MD_OP[2] & ~MD_OP[0] & (MD_In_A == {1'b1, {(DW-1){1'b0}}}) &
                    (MD_In_B == {DW{1'b1}});

  md_operand_prep #(.W(DW)) u_in_prep (
    .a_i     (MD_In_A),
    .b_i     (MD_In_B),
    .a_neg_i (a_neg_c),
    .b_neg_i (b_neg_c),
    .a_o     (a_mag_c),
    .b_o     (b_mag_c)
  );

  // acc_q holds {product_hi, product_lo} for multiply and {remainder, quotient} for divide.
  assign div_trial_c = acc_q[PW-1:DW-1] - {1'b0, b_mag_q};
`ifdef MUL_DIV_FAST_MUL_EN
  assign mul_full_c  = PW'(acc_q[DW-1:0]) * PW'(b_mag_q);
`else
  assign mul_sum_c   = {1'b0, acc_q[PW-1:DW]} + ({1'b0, b_mag_q} & {(DW+1){acc_q[0]}});
`endif

  // Placing the remainder in the upper half lets one 2*DW negate serve REM as well.
  assign div_val_c = op_q[1] ? {acc_q[PW-1:DW], DW'(0)} : {DW'(0), acc_q[DW-1:0]};

  md_operand_prep #(.W(PW)) u_out_prep (
    .a_i     (acc_q),
    .b_i     (div_val_c),
    .a_neg_i (neg_q),
    .b_neg_i (neg_q),
    .a_o     (mul_fix_c),
    .b_o     (div_fix_c)
  );

  always_comb begin
    if (op_q[2]) begin
      res_c = op_q[1] ? div_fix_c[PW-1:DW] : div_fix_c[DW-1:0];
    end else begin
      res_c = (op_q == MD_MUL) ? mul_fix_c[DW-1:0] : mul_fix_c[PW-1:DW];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    b_mag_d = b_mag_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MD_Start) begin
          op_d    = MD_OP;
          neg_d   = neg_c;
          b_mag_d = b_mag_c;
          cnt_d   = CW'(DW - 1);
          acc_d   = {DW'(0), a_mag_c};
          state_d = ST_CALC;
          if (b_zero_c) begin
            acc_d   = {MD_In_A, {DW{1'b1}}};
            neg_d   = 1'b0;
            state_d = ST_DONE;
          end else if (ovf_c) begin
            acc_d   = {DW'(0), MD_In_A};
            neg_d   = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q[2]) begin
          if (!div_trial_c[DW]) begin
            acc_d = {div_trial_c[DW-1:0], acc_q[DW-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[PW-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end
        end else begin
`ifdef MUL_DIV_FAST_MUL_EN
          acc_d   = mul_full_c;
          state_d = ST_DONE;
`else
          acc_d = {mul_sum_c, acc_q[DW-1:1]};
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_DONE: begin
        out_d   = res_c;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      b_mag_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      b_mag_q <= b_mag_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign MD_Ready = ready_q;
  assign MD_Busy  = busy_q;
  assign MD_Out   = out_q;
  assign MD_Valid = valid_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit results, latency, handshake and reset abort.
module tb_mul_div_unit;

  logic        Clk;
  logic        Reset;
  logic        MD_Start;
  logic [2:0]  MD_OP;
  logic [31:0] MD_In_A;
  logic [31:0] MD_In_B;
  logic        MD_Ready;
  logic        MD_Busy;
  logic [31:0] MD_Out;
  logic        MD_Valid;

  mul_div_unit #(.DWIDTH(32)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .MD_Start (MD_Start),
    .MD_OP    (MD_OP),
    .MD_In_A  (MD_In_A),
    .MD_In_B  (MD_In_B),
    .MD_Ready (MD_Ready),
    .MD_Busy  (MD_Busy),
    .MD_Out   (MD_Out),
    .MD_Valid (MD_Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_acc  = 0;
  int          n_done = 0;
  logic [31:0] last_res = '0;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (op)
      3'b000: begin p = ua * ub; r = p[31:0];  end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MUL_DIV_FAST_MUL_EN
    if (!op[2]) return 2;
`endif
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // One clock: record an acceptance at the coming edge, then sample at the falling edge.
  task automatic step();
    exp_t e;
    if (Reset) begin
      exp_q.delete();
    end else if (MD_Start && MD_Ready) begin
      exp_q.push_back('{res: model(MD_OP, MD_In_A, MD_In_B), at: cyc + 1 + lat(MD_OP, MD_In_A, MD_In_B)});
      n_acc++;
    end
    @(negedge Clk);
    if (MD_Valid) begin
      n_done++;
      check("valid_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_res = e.res;
        check("result", MD_Out, e.res);
        check("latency", 32'(cyc), 32'(e.at));
      end
    end
  endtask

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 100 && n_done < tgt; i++) step();
    check("done_timeout", 32'(n_done >= tgt), 32'd1);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int tgt;
    tgt      = n_done + 1;
    MD_OP    = op;
    MD_In_A  = a;
    MD_In_B  = b;
    MD_Start = 1'b1;
    step();
    MD_Start = 1'b0;
    MD_In_A  = $urandom;
    MD_In_B  = $urandom;
    MD_OP    = 3'($urandom_range(0, 7));
    wait_done(tgt);
  endtask

  initial begin
    int base_acc, base_done;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    Reset    = 1'b1;
    MD_Start = 1'b0;
    MD_OP    = '0;
    MD_In_A  = '0;
    MD_In_B  = '0;
    step();
    step();
    check("rst_ready", 32'(MD_Ready), 32'd1);
    check("rst_busy",  32'(MD_Busy),  32'd0);
    check("rst_valid", 32'(MD_Valid), 32'd0);
    check("rst_out",   MD_Out,        32'd0);
    Reset = 1'b0;
    step();

    do_op(3'b000, 32'd7,          32'hFFFF_FFFD);
    check("mul_7xm3", MD_Out, 32'hFFFF_FFEB);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2);
    do_op(3'b101, 32'd100,        32'd7);
    do_op(3'b111, 32'd100,        32'd7);
    do_op(3'b101, 32'd5,          32'd0);
    do_op(3'b111, 32'd5,          32'd0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd0);
    do_op(3'b100, 32'h0000_0007, 32'hFFFF_FFFE);

    repeat (3) step();
    check("out_hold", MD_Out, last_res);

    // Start held high with new operands while the first op is in flight
    base_acc  = n_acc;
    base_done = n_done;
    MD_OP     = 3'b101;
    MD_In_A   = 32'd100;
    MD_In_B   = 32'd7;
    MD_Start  = 1'b1;
    step();
    MD_OP   = 3'b011;
    MD_In_A = 32'hFFFF_FFFF;
    MD_In_B = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_ready", 32'(MD_Ready), 32'd0);
      check("busy_busy",  32'(MD_Busy),  32'd1);
    end
    for (int i = 0; i < 100 && n_acc < base_acc + 2; i++) step();
    MD_Start = 1'b0;
    check("second_accept", 32'(n_acc - base_acc), 32'd2);
    wait_done(base_done + 2);
    check("second_result", MD_Out, 32'hFFFF_FFFE);

    // Reset ten cycles into a divide
    MD_OP    = 3'b100;
    MD_In_A  = 32'd1000;
    MD_In_B  = 32'd3;
    MD_Start = 1'b1;
    step();
    MD_Start = 1'b0;
    repeat (9) step();
    Reset = 1'b1;
    step();
    check("abort_out",   MD_Out,        32'd0);
    check("abort_ready", 32'(MD_Ready), 32'd1);
    check("abort_busy",  32'(MD_Busy),  32'd0);
    check("abort_valid", 32'(MD_Valid), 32'd0);
    Reset = 1'b0;
    repeat (40) step();
    check("abort_no_pulse", 32'(n_done), 32'(base_done + 2));
    do_op(3'b000, 32'd3, 32'd4);
    check("mul_3x4", MD_Out, 32'd12);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      do_op(rop, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
